core_rst_seq: RTL and testbench

//  Sequences core reset from cfgreg power-on level and soft-reset pulse requests.

---
 rtl/core_rst_seq.sv | 130 +++++++++++++
 tb/tb_core_rst_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/core_rst_seq.sv
// rtl/core_rst_seq.sv - core reset sequencer: power-on/soft-reset requests, drain, timed reset hold, boot vector capture
module core_rst_seq #(
   parameter int XLEN     = 32,
   parameter int RST_HOLD = 16,
   parameter int DRAIN_TO = 256
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pwron_req,
   input  logic            srst_req,
   input  logic [XLEN-1:0] bootvec_in,
   input  logic            core_idle,
   output logic            core_rstn,
   output logic [XLEN-1:0] core_bootvec,
   output logic            drain_req,
   output logic            seq_busy,
   output logic [2:0]      seq_state,
   output logic            drain_tmo
);

   localparam int CNT_MAX = (RST_HOLD > DRAIN_TO) ? RST_HOLD : DRAIN_TO;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TO - 1);

   generate
      if (RST_HOLD < 1) begin : g_bad_hold
         $error("core_rst_seq: RST_HOLD must be >= 1");
      end
      if (DRAIN_TO < 1) begin : g_bad_drain
         $error("core_rst_seq: DRAIN_TO must be >= 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_HOLD  = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [XLEN-1:0]   bootvec_q, bootvec_d;
   logic              tmo_q, tmo_d;
   logic              pend_q, pend_d;
   logic              rstn_q, drain_q, busy_q;

   // Saturating increment so a long stall can never wrap back into a match
   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d   = S_OFF;
      cnt_d     = cnt_inc;
      bootvec_d = bootvec_q;
      tmo_d     = tmo_q;
      pend_d    = pend_q;
      case (state_q)
         S_OFF: begin
            cnt_d = '0;
            if (pwron_req) begin
               state_d = S_HOLD;
               tmo_d   = 1'b0;
            end
         end
         S_HOLD: begin
            state_d = S_HOLD;
            if (!pwron_req) begin
               state_d = S_OFF;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d   = S_RUN;
               cnt_d     = '0;
               bootvec_d = bootvec_in;
               pend_d    = 1'b0;
            end
         end
         S_RUN: begin
            state_d = S_RUN;
            cnt_d   = '0;
            if (srst_req || !pwron_req) begin
               state_d = S_DRAIN;
               pend_d  = srst_req;
            end
         end
         S_DRAIN: begin
            state_d = S_DRAIN;
            if (core_idle || (cnt_q == DRAIN_LAST)) begin
               if (!core_idle) tmo_d = 1'b1;
               cnt_d   = '0;
               state_d = pwron_req ? S_HOLD : S_OFF;
            end
         end
         default: begin
            state_d = S_OFF;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_OFF;
         cnt_q     <= '0;
         bootvec_q <= '0;
         tmo_q     <= 1'b0;
         pend_q    <= 1'b0;
         rstn_q    <= 1'b0;
         drain_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bootvec_q <= bootvec_d;
         tmo_q     <= tmo_d;
         pend_q    <= pend_d;
         rstn_q    <= (state_d == S_RUN) || (state_d == S_DRAIN);
         drain_q   <= (state_d == S_DRAIN);
         busy_q    <= (state_d == S_HOLD) || (state_d == S_DRAIN);
      end
   end

   assign core_rstn    = rstn_q;
   assign core_bootvec = bootvec_q;
   assign drain_req    = drain_q;
   assign seq_busy     = busy_q;
   assign seq_state    = state_q;
   assign drain_tmo    = tmo_q;

endmodule

// File: tb/tb_core_rst_seq.sv
// tb/tb_core_rst_seq.sv - directed bench for core_rst_seq (RST_HOLD=16, DRAIN_TO=8)
module tb_core_rst_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        pwron_req;
   logic        srst_req;
   logic [31:0] bootvec_in;
   logic        core_idle;
   logic        core_rstn;
   logic [31:0] core_bootvec;
   logic        drain_req;
   logic        seq_busy;
   logic [2:0]  seq_state;
   logic        drain_tmo;

   int total = 0;
   int bad   = 0;

   core_rst_seq #(.XLEN(32), .RST_HOLD(16), .DRAIN_TO(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .pwron_req    (pwron_req),
      .srst_req     (srst_req),
      .bootvec_in   (bootvec_in),
      .core_idle    (core_idle),
      .core_rstn    (core_rstn),
      .core_bootvec (core_bootvec),
      .drain_req    (drain_req),
      .seq_busy     (seq_busy),
      .seq_state    (seq_state),
      .drain_tmo    (drain_tmo)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rstn"},    32'(core_rstn),    32'd0);
      check({tag, "_bootvec"}, core_bootvec,      32'd0);
      check({tag, "_drain"},   32'(drain_req),    32'd0);
      check({tag, "_busy"},    32'(seq_busy),     32'd0);
      check({tag, "_state"},   32'(seq_state),    32'd0);
      check({tag, "_tmo"},     32'(drain_tmo),    32'd0);
   endtask

   // From HOLD entry: 15 more low cycles, then the first RUN cycle
   task automatic finish_hold(input string tag, input logic [31:0] exp_bv);
      for (int i = 0; i < 15; i++) cycle();
      check({tag, "_last_hold_rstn"}, 32'(core_rstn), 32'd0);
      check({tag, "_last_hold_state"}, 32'(seq_state), 32'd1);
      cycle();
      check({tag, "_run_rstn"},  32'(core_rstn), 32'd1);
      check({tag, "_run_state"}, 32'(seq_state), 32'd2);
      check({tag, "_run_busy"},  32'(seq_busy),  32'd0);
      check({tag, "_bootvec"},   core_bootvec,   exp_bv);
   endtask

   initial begin
      rst        = 1'b1;
      pwron_req  = 1'b0;
      srst_req   = 1'b0;
      bootvec_in = 32'h8000_0000;
      core_idle  = 1'b0;
      cycle();
      cycle();
      check_reset_vals("reset");

      // Power-up
      rst       = 1'b0;
      pwron_req = 1'b1;
      cycle();
      check("pu_hold_state", 32'(seq_state), 32'd1);
      check("pu_hold_busy",  32'(seq_busy),  32'd1);
      check("pu_hold_rstn",  32'(core_rstn), 32'd0);
      finish_hold("pu", 32'h8000_0000);

      // Bootvec isolation during RUN
      bootvec_in = 32'h1234_5678;
      cycle(); cycle(); cycle();
      check("iso_bootvec", core_bootvec, 32'h8000_0000);

      // Soft reset with idle after 3 drain cycles
      srst_req = 1'b1;
      cycle();
      srst_req = 1'b0;
      check("sr_drain_state", 32'(seq_state), 32'd3);
      check("sr_drain_req",   32'(drain_req), 32'd1);
      check("sr_drain_rstn",  32'(core_rstn), 32'd1);
      check("sr_drain_busy",  32'(seq_busy),  32'd1);
      cycle();
      cycle();
      check("sr_drain_req3", 32'(drain_req), 32'd1);
      core_idle = 1'b1;
      cycle();
      core_idle = 1'b0;
      check("sr_hold_state", 32'(seq_state), 32'd1);
      check("sr_hold_drain", 32'(drain_req), 32'd0);
      check("sr_hold_rstn",  32'(core_rstn), 32'd0);
      check("sr_hold_tmo",   32'(drain_tmo), 32'd0);
      finish_hold("sr", 32'h1234_5678);
      check("sr_run_tmo", 32'(drain_tmo), 32'd0);

      // Drain timeout: 8 DRAIN cycles then reset
      srst_req = 1'b1;
      cycle();
      srst_req = 1'b0;
      for (int i = 0; i < 7; i++) cycle();
      check("to_last_drain_state", 32'(seq_state), 32'd3);
      check("to_last_drain_rstn",  32'(core_rstn), 32'd1);
      check("to_last_drain_tmo",   32'(drain_tmo), 32'd0);
      cycle();
      check("to_hold_state", 32'(seq_state), 32'd1);
      check("to_hold_rstn",  32'(core_rstn), 32'd0);
      check("to_hold_tmo",   32'(drain_tmo), 32'd1);
      finish_hold("to", 32'h1234_5678);
      check("to_run_tmo", 32'(drain_tmo), 32'd1);

      // Power-off with idle core
      core_idle = 1'b1;
      pwron_req = 1'b0;
      cycle();
      check("po_drain_state", 32'(seq_state), 32'd3);
      cycle();
      check("po_off_state", 32'(seq_state), 32'd0);
      check("po_off_rstn",  32'(core_rstn), 32'd0);
      check("po_off_busy",  32'(seq_busy),  32'd0);
      check("po_off_drain", 32'(drain_req), 32'd0);
      check("po_off_tmo",   32'(drain_tmo), 32'd1);

      // srst_req ignored in OFF
      srst_req = 1'b1;
      cycle();
      srst_req = 1'b0;
      check("off_srst_state", 32'(seq_state), 32'd0);

      // OFF->HOLD clears drain_tmo; abort at cnt=5
      core_idle = 1'b0;
      pwron_req = 1'b1;
      cycle();
      check("ab_hold_state", 32'(seq_state), 32'd1);
      check("ab_hold_tmo",   32'(drain_tmo), 32'd0);
      for (int i = 0; i < 5; i++) cycle();
      rst = 1'b1;
      cycle();
      check_reset_vals("abort");
      rst = 1'b0;
      cycle();
      check("ab_rehold_state", 32'(seq_state), 32'd1);
      finish_hold("ab", 32'h1234_5678);

      // Simultaneous srst and pwron drop in RUN: DRAIN then OFF
      srst_req  = 1'b1;
      pwron_req = 1'b0;
      cycle();
      srst_req = 1'b0;
      check("sim_drain_state", 32'(seq_state), 32'd3);
      cycle();
      check("sim_wait_state", 32'(seq_state), 32'd3);
      core_idle = 1'b1;
      cycle();
      check("sim_off_state", 32'(seq_state), 32'd0);
      check("sim_off_rstn",  32'(core_rstn), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
